// File: rtl/vdispatch_issue_pkg.sv
// Shared vector-dispatch constants used by the issue stage and the dispatcher.
// Group-count helper shared so both sides agree on how a vector length is split.
package vdispatch_issue_pkg;

  localparam int unsigned VD_NUMSTAGES  = 2;
  localparam int unsigned VD_INSTRWIDTH = 151;
  localparam int unsigned VD_ELMWIDTH   = 6;
  localparam int unsigned VD_COUNTWIDTH = 4;
  localparam int unsigned VD_NUMLANES   = 4;
  localparam int unsigned VD_VLWIDTH    = 7;
  localparam int unsigned VD_MAXVL      = 64;

  // ceil(min(vl, VD_MAXVL) / lanes)
  function automatic int unsigned vd_groups(input int unsigned vl, input int unsigned lanes);
    int unsigned vle;
    vle = (vl > VD_MAXVL) ? VD_MAXVL : vl;
    return (vle + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/vdispatch_issue_slots.sv
// Per-slot valid/count shadow of the dispatcher: shifts toward the tail and
// counts down the tail slot's remaining lane groups.
module vdispatch_issue_slots
  import vdispatch_issue_pkg::*;
#(
  parameter int unsigned NUMSTAGES  = VD_NUMSTAGES,
  parameter int unsigned COUNTWIDTH = VD_COUNTWIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_flush,
  input  logic                  i_shift,
  input  logic                  i_dec,
  input  logic                  i_v,
  input  logic [COUNTWIDTH-1:0] i_c,
  output logic [NUMSTAGES-1:0]  o_v,
  output logic [COUNTWIDTH-1:0] o_tail_c
);

  localparam int unsigned T = NUMSTAGES - 1;

  logic [NUMSTAGES-1:0]  r_v;
  logic [COUNTWIDTH-1:0] r_c [NUMSTAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v <= '0;
      for (int k = 0; k < int'(NUMSTAGES); k++) r_c[k] <= '0;
    end else if (i_flush) begin
      r_v <= '0;
      for (int k = 0; k < int'(NUMSTAGES); k++) r_c[k] <= '0;
    end else if (i_shift) begin
      for (int k = int'(NUMSTAGES) - 1; k > 0; k--) begin
        r_v[k] <= r_v[k-1];
        r_c[k] <= r_c[k-1];
      end
      r_v[0] <= i_v;
      r_c[0] <= i_c;
    end else if (i_dec) begin
      // Shift and decrement never coincide: decrement implies the tail is still busy.
      r_c[T] <= r_c[T] - COUNTWIDTH'(1);
    end
  end

  assign o_v      = r_v;
  assign o_tail_c = r_c[T];

endmodule

// File: rtl/vdispatch_issue.sv
// Vector dispatch issue stage: accepts decoded vector instructions and drives
// the dispatcher's shift/insert/decrement controls, retiring the tail when done.
module vdispatch_issue
  import vdispatch_issue_pkg::*;
#(
  parameter int unsigned NUMSTAGES  = VD_NUMSTAGES,
  parameter int unsigned INSTRWIDTH = VD_INSTRWIDTH,
  parameter int unsigned ELMWIDTH   = VD_ELMWIDTH,
  parameter int unsigned COUNTWIDTH = VD_COUNTWIDTH,
  parameter int unsigned NUMLANES   = VD_NUMLANES,
  parameter int unsigned VLWIDTH    = VD_VLWIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTRWIDTH-1:0] in_instr,
  input  logic [VLWIDTH-1:0]    in_vl,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  shift,
  output logic                  rotate,
  output logic [NUMSTAGES-1:0]  increment,
  output logic [INSTRWIDTH-1:0] inshift_instr,
  output logic                  inshift_first,
  output logic [ELMWIDTH-1:0]   inshift_rdelm,
  output logic [ELMWIDTH-1:0]   inshift_wrelm,
  output logic [COUNTWIDTH-1:0] inshift_count,
  output logic                  rdelm_add_sub,
  output logic                  wrelm_add_sub,
  output logic                  count_add_sub,
  output logic [ELMWIDTH-1:0]   rdelm_valuetoadd,
  output logic [ELMWIDTH-1:0]   wrelm_valuetoadd,
  output logic [COUNTWIDTH-1:0] count_valuetoadd,
  output logic [NUMSTAGES-1:0]  slot_valid,
  output logic                  retire,
  output logic                  busy
);

  localparam int unsigned T = NUMSTAGES - 1;

  logic [31:0]           w_groups;
  logic [COUNTWIDTH-1:0] w_count;
  logic [NUMSTAGES-1:0]  w_v;
  logic [COUNTWIDTH-1:0] w_tail_c;
  logic                  w_tail_done;
  logic                  w_adv;
  logic                  w_go;
  logic                  w_accept;
  logic                  w_inc;

  assign w_groups = vd_groups(32'(in_vl), NUMLANES);
  assign w_count  = COUNTWIDTH'(w_groups - 32'd1);

  assign w_tail_done = w_v[T] & (w_tail_c == '0);
  assign w_adv       = ~w_v[T] | w_tail_done;
  assign w_go        = ~stall & ~flush;
  assign in_ready    = w_go & w_adv;
  assign w_accept    = in_valid & in_ready;
  assign shift       = w_go & w_adv & ((|w_v) | w_accept);
  assign w_inc       = w_go & w_v[T] & (w_tail_c != '0);
  assign retire      = w_go & w_tail_done;

  always_comb begin
    increment    = '0;
    increment[T] = w_inc;
  end

  assign inshift_instr    = in_instr;
  assign inshift_first    = 1'b1;
  assign inshift_rdelm    = '0;
  assign inshift_wrelm    = '0;
  assign inshift_count    = w_count;
  assign rotate           = 1'b0;
  assign rdelm_add_sub    = 1'b0;
  assign wrelm_add_sub    = 1'b0;
  assign count_add_sub    = 1'b1;
  assign rdelm_valuetoadd = ELMWIDTH'(NUMLANES);
  assign wrelm_valuetoadd = ELMWIDTH'(NUMLANES);
  assign count_valuetoadd = COUNTWIDTH'(1);

  assign slot_valid = w_v;
  assign busy       = |w_v;

  // A zero-length instruction completes the handshake but occupies no slot.
  vdispatch_issue_slots #(
    .NUMSTAGES  (NUMSTAGES),
    .COUNTWIDTH (COUNTWIDTH)
  ) u_slots (
    .clk      (clk),
    .resetn   (resetn),
    .i_flush  (flush),
    .i_shift  (shift),
    .i_dec    (w_inc),
    .i_v      (w_accept & (w_groups != 32'd0)),
    .i_c      (w_count),
    .o_v      (w_v),
    .o_tail_c (w_tail_c)
  );

endmodule

// File: doc/vdispatch_issue.md
VDISPATCH_ISSUE -- requirements
Module: vdispatch_issue

Interface
REQ-001 SHALL have parameter NUMSTAGES, default 2, giving the number of dispatcher slots fed; the tail slot is index T = NUMSTAGES-1.
REQ-002 SHALL have parameter INSTRWIDTH, default 151, giving the decoded vector instruction width.
REQ-003 SHALL have parameter ELMWIDTH, default 6, giving the element-index width.
REQ-004 SHALL have parameter COUNTWIDTH, default 4, giving the lane-group count width.
REQ-005 SHALL have parameter NUMLANES, default 4, giving the number of elements processed per lane group.
REQ-006 SHALL have parameter VLWIDTH, default 7, giving the vector-length width.
REQ-007 SHALL have ports clk (in, 1, clock) and resetn (in, 1, reset; one clock, reset asynchronous and active-low).
REQ-008 SHALL have in_valid (in, 1), in_ready (out, 1), in_instr (in, INSTRWIDTH) and in_vl (in, VLWIDTH) as the upstream handshake.
REQ-009 SHALL have stall (in, 1) as the downstream hold and flush (in, 1) as the synchronous squash-all.
REQ-010 SHALL have shift (out, 1), rotate (out, 1) and increment (out, NUMSTAGES) as dispatcher controls.
REQ-011 SHALL have inshift_instr (out, INSTRWIDTH), inshift_first (out, 1), inshift_rdelm (out, ELMWIDTH), inshift_wrelm (out, ELMWIDTH) and inshift_count (out, COUNTWIDTH) as dispatcher insert data.
REQ-012 SHALL have rdelm_add_sub, wrelm_add_sub and count_add_sub (out, 1 each), plus rdelm_valuetoadd and wrelm_valuetoadd (out, ELMWIDTH) and count_valuetoadd (out, COUNTWIDTH).
REQ-013 SHALL have slot_valid (out, NUMSTAGES, per-slot occupancy), retire (out, 1, tail instruction complete) and busy (out, 1).

Function
REQ-014 SHALL compute the effective length as vle = min(in_vl, 64), the group count as groups = ceil(vle/NUMLANES), and drive inshift_count = groups-1, truncated to COUNTWIDTH.
REQ-015 SHALL drive inshift_instr = in_instr, inshift_first = 1, inshift_rdelm = 0 and inshift_wrelm = 0.
REQ-016 SHALL tie rotate = 0, rdelm_add_sub = 0, wrelm_add_sub = 0 and count_add_sub = 1, with rdelm/wrelm_valuetoadd = NUMLANES and count_valuetoadd = 1.
REQ-017 SHALL hold per slot a valid bit v[k] and a shadow count c[k] mirroring the dispatcher count field.
REQ-018 SHALL define tail_done = v[T] & (c[T] == 0) and adv = ~v[T] | tail_done.
REQ-019 SHALL define in_ready = ~stall & ~flush & adv, and accept = in_valid & in_ready.
REQ-020 SHALL assert shift = ~stall & ~flush & adv & (|v | accept); on shift, v[k+1] <= v[k], c[k+1] <= c[k], v[0] <= accept & (vle != 0), and c[0] <= groups-1.
REQ-021 SHALL accept an instruction with vle == 0 (handshake completes) without making any slot valid.
REQ-022 SHALL assert increment[T] = ~stall & ~flush & v[T] & (c[T] != 0), decrementing c[T] by 1 in the same cycle; all other increment bits SHALL be 0.
REQ-023 SHALL assert retire = ~stall & ~flush & tail_done for exactly one cycle per instruction.
REQ-024 SHALL, while stall = 1, hold all state and drive shift, increment, retire and in_ready to 0.
REQ-025 SHALL let flush take priority over every other event: next cycle all v and c are 0, and during the flush cycle shift, increment, retire and in_ready are 0.
REQ-026 SHALL drive slot_valid = v and busy = |v.

Reset
REQ-027 SHALL, while resetn = 0, asynchronously clear all v and c; shift, increment, retire and busy are then 0, and in_ready follows REQ-019 (1 when stall = 0 and flush = 0).

Structure
REQ-028 SHALL take NUMSTAGES, NUMLANES and the width constants from a shared vector-dispatch constants package also used by the dispatcher.
REQ-029 SHALL place the per-slot v/c shift-and-decrement array in one sub-module, vdispatch_issue_slots.

Verification
REQ-030 SHALL cover: after reset, in_vl = 8 accepted -> inshift_count = 1; the instruction shifts to the tail after 2 shifts; increment[T] = 1 for 1 cycle; retire pulses on the next cycle.
REQ-031 SHALL cover: in_vl = 0 -> in_ready = 1, handshake completes, slot_valid stays 0, no retire.
REQ-032 SHALL cover: in_vl = 100 -> inshift_count = 15, and exactly 15 increment cycles occur before retire.
REQ-033 SHALL cover: stall held for 3 cycles mid-count -> c[T] frozen, shift, increment and retire are 0, and the count resumes unchanged afterwards.
REQ-034 SHALL cover: flush with both slots valid -> next cycle slot_valid = 0 and busy = 0, with no retire.
REQ-035 SHALL cover: resetn asserted mid-count -> slot_valid = 0 immediately, with no clock edge needed.
